multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// - Multi-cycle control FSM for the 32-bit MIPS-subset core; sequences fetch/decode/execute/memory/writeback.
// - Drives every datapath select, incl. ext_sel for the immediate extender (1=sign-extend, 0=zero-extend).
// - Sits beside the datapath: consumes IR opcode/funct and ALU zero; handshakes a single-port memory.
// PARAMETERS
// - DATA_WIDTH  32  datapath width; only the ALU-op width is derived from it, nothing else is data-dependent
// - OPC_WIDTH   6   opcode and funct field width
// PORTS
// - clk         in   1  sole clock; all state updates on rising edge
// - rst         in   1  synchronous, active-high reset
// - opcode      in   6  IR[31:26], stable from DECODE onward
// - funct       in   6  IR[5:0]
// - alu_zero    in   1  ALU zero flag, valid in BRANCH
// - mem_ready   in   1  memory completes the current request this cycle
// - mem_req     out  1  memory request, held high until mem_ready
// - mem_we      out  1  write qualifier for mem_req (SW only)
// - iord        out  1  0=PC address, 1=ALUOut address
// - ir_write    out  1  load IR (single-cycle pulse)
// - pc_write    out  1  load PC (single-cycle pulse)
// - pc_src      out  2  0=PC+4, 1=branch target, 2=jump target
// - alu_src_a   out  1  0=PC, 1=rs
// - alu_src_b   out  2  0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2
// - alu_op      out  4  ALU function code
// - ext_sel     out  1  1=sign-extend imm, 0=zero-extend
// - reg_dst     out  1  0=rt, 1=rd
// - mem_to_reg  out  1  0=ALUOut, 1=MDR
// - reg_write   out  1  register-file write enable (single-cycle pulse)
// - illegal     out  1  one-cycle pulse on undecodable opcode/funct
// BEHAVIOUR
// - Outputs are a Moore decode of state plus mem_ready/alu_zero qualifiers; while rst=1 all outputs are 0.
// - rst=1 at a clock edge -> state=FETCH, latched ext_sel=0; mid-instruction reset abandons it, no writes issue.
// - FETCH: mem_req=1, iord=0; hold until mem_ready; in the mem_ready cycle ir_write=1, pc_write=1,
//   alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0 -> DECODE.
// - DECODE (1 cycle): ext_sel latched from opcode (ADDI/LW/SW/BEQ=1, ANDI/ORI=0, others=0); ALU computes PC+(imm<<2).
//   Next: R-type->EXEC_R; ADDI/ANDI/ORI->EXEC_I; LW/SW->MEM_ADDR; BEQ->BRANCH; J->JUMP; else illegal=1 -> FETCH.
// - Opcodes: R 000000, J 000010, BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011.
// - R funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010; other funct -> illegal=1, FETCH, no write.
// - EXEC_R -> WB_R (reg_dst=1, reg_write=1) -> FETCH.  EXEC_I -> WB_I (reg_dst=0, reg_write=1) -> FETCH.
// - MEM_ADDR (alu_src_b=2, ADD): LW->MEM_RD, SW->MEM_WR. MEM_RD/MEM_WR: mem_req=1, iord=1 (mem_we=1 in MEM_WR),
//   hold until mem_ready; MEM_RD->WB_MEM (mem_to_reg=1, reg_write=1)->FETCH; MEM_WR->FETCH.
// - BRANCH: alu_op=SUB on rs,rt; pc_src=1; pc_write=alu_zero -> FETCH. JUMP: pc_src=2, pc_write=1 -> FETCH.
// - ext_sel holds latched value from DECODE until next DECODE; mem_ready outside a request state is ignored.
// - Latency (mem_ready same cycle as req): R/I 4, LW 5, SW 4, BEQ/J 3 cycles; each wait cycle adds 1.
// - Unused state encodings -> FETCH next cycle, outputs 0.
// STRUCTURE
// - Package core_ctrl_pkg: opcode/funct localparams, ALU_OP codes (ADD 0010, SUB 0110, AND 0000, OR 0001,
//   SLT 0111), state encoding enum, alu_src_b/pc_src select constants.
// - One sub-module: alu_op_decode (combinational: state-class + opcode + funct -> alu_op, funct_valid).
// - FSM register + next-state + output decode stay in this module; no other hierarchy.
// TESTING
// - Reset: rst=1 two cycles mid-LW at MEM_RD -> all outputs 0, next state FETCH, no reg_write pulse.
// - ADDI imm=0xFFFF, mem_ready=1 always -> ext_sel=1 from DECODE, reg_write at cycle 4, reg_dst=0.
// - ORI imm=0x8000 -> ext_sel=0, alu_op=0001, one reg_write; then ADD funct 100000 -> alu_op=0010, reg_dst=1.
// - LW with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> mem_req held, ir_write once, total 10 cycles.
// - BEQ alu_zero=1 -> pc_write=1,pc_src=1 in cycle 3; alu_zero=0 -> pc_write=0; J -> pc_src=2,pc_write=1.
// - Opcode 111111 and R funct 000001 -> illegal pulse one cycle, no reg_write/mem_req, back to FETCH.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: instruction
// field codes, ALU function codes, FSM state encoding and datapath select values.
// Latency: n/a (package). Backpressure: n/a.
package core_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // FSM state encoding; codes 12..15 are unused and recover to FETCH
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // What the ALU is being asked to do in the current state
    typedef enum logic [2:0] {
        ACLS_NONE,   // ALU unused: drive code 0
        ACLS_ADD,    // address / PC arithmetic
        ACLS_SUB,    // branch compare
        ACLS_FUNCT,  // R-type, chosen by funct
        ACLS_IMM     // I-type ALU op, chosen by opcode
    } alu_cls_e;

    // Sign-extension is needed for arithmetic / address / branch immediates;
    // logical immediates and everything else use zero-extension.
    function automatic logic ext_is_sign(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ALU function decode from state class, opcode and funct; also flags legal funct.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of inputs).
module alu_op_decode
    import core_ctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 4,
    parameter int OPC_WIDTH = 6
) (
    input  alu_cls_e             cls,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic [OPC_WIDTH-1:0] funct,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 funct_valid
);

    logic [ALU_OP_W-1:0] funct_op;

    always_comb begin
        funct_valid = 1'b1;
        funct_op    = ALU_ADD;
        case (funct)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_SLT:  funct_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = '0;
        case (cls)
            ACLS_ADD:   alu_op = ALU_ADD;
            ACLS_SUB:   alu_op = ALU_SUB;
            ACLS_FUNCT: alu_op = funct_op;
            ACLS_IMM: begin
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default:    alu_op = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset core: fetch/decode/execute/mem/writeback.
// Latency: R/I 4, LW 5, SW 4, BEQ/J 3 cycles with zero-wait memory; +1 per wait cycle.
// Backpressure: holds mem_req in FETCH/MEM_RD/MEM_WR until mem_ready; ignores it elsewhere.
//
// Ports: clk/rst (sync active-high); opcode/funct from IR; alu_zero from ALU;
// mem_req/mem_we/mem_ready memory handshake; remaining outputs are datapath selects
// and single-cycle write enables; illegal pulses on an undecodable instruction.
module multicycle_control
    import core_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OPC_WIDTH  = 6,
    parameter int ALU_OP_W   = $clog2(DATA_WIDTH) - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic [OPC_WIDTH-1:0] funct,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 ext_sel,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal
);

    logic [3:0] state_q, state_d;
    logic       ext_q, ext_d;
    alu_cls_e   alu_cls;
    logic       funct_valid;

    logic is_r, is_i, is_mem, is_beq, is_j, decodable;

    assign is_r      = (opcode == OP_RTYPE);
    assign is_i      = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_j      = (opcode == OP_J);
    // R-type with an unknown funct is rejected in DECODE, so no write is ever issued
    assign decodable = (is_r && funct_valid) || is_i || is_mem || is_beq || is_j;

    alu_op_decode #(
        .ALU_OP_W  (ALU_OP_W),
        .OPC_WIDTH (OPC_WIDTH)
    ) u_alu_op_decode (
        .cls         (alu_cls),
        .opcode      (opcode),
        .funct       (funct),
        .alu_op      (alu_op),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
        end
    end

    // Next state
    always_comb begin
        state_d = S_FETCH;
        ext_d   = ext_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                ext_d = ext_is_sign(opcode);
                if (is_r && funct_valid) state_d = S_EXEC_R;
                else if (is_i)           state_d = S_EXEC_I;
                else if (is_mem)         state_d = S_MEM_ADDR;
                else if (is_beq)         state_d = S_BRANCH;
                else if (is_j)           state_d = S_JUMP;
                else                     state_d = S_FETCH;
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; everything forced low while rst is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_cls    = ACLS_NONE;
        ext_sel    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            ext_sel = ext_q;
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        alu_cls   = ACLS_ADD;
                    end
                end
                S_DECODE: begin
                    // The extender feeds the branch-target add this cycle, so the
                    // select comes straight from the opcode rather than the latch
                    ext_sel   = ext_is_sign(opcode);
                    alu_src_b = SRCB_IMM_SH;
                    alu_cls   = ACLS_ADD;
                    illegal   = !decodable;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_cls   = ACLS_FUNCT;
                end
                S_WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_cls   = ACLS_IMM;
                end
                S_WB_I:     reg_write = 1'b1;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_cls   = ACLS_ADD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_WB_MEM: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_cls   = ACLS_SUB;
                    pc_src    = PCSRC_BRANCH;
                    pc_write  = alu_zero;
                end
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                default:    ext_sel = 1'b0;
            endcase
        end
    end

endmodule
